// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and the transmitter.
//   uart_state_e      : frame state machine encoding
//   DEF_*             : default parameter values for the UART blocks
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int unsigned DEF_CLK_PER_BIT = 2604;
  localparam int unsigned DEF_DATA_BITS   = 8;
  localparam bit          DEF_PARITY_EN   = 1'b0;
  localparam bit          DEF_PARITY_ODD  = 1'b0;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous input.
//   clk, rst_n : clock and async active-low reset (both flops reset to RST_VAL)
//   d          : asynchronous input
//   q          : synchronized output
module uart_sync #(
  parameter bit RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Metastability-settling chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: start/data/optional parity/stop, LSB first.
//   clk, rst_n : clock and async active-low reset
//   RX         : asynchronous serial line, idle high
//   clr_rdy    : consumer acknowledge, clears rdy and ovr_err
//   rdy        : received frame available
//   cmd        : last received data word
//   frm_err    : stop bit of last frame sampled low
//   par_err    : parity mismatch in last frame (0 when parity disabled)
//   ovr_err    : a frame completed while rdy was still high (sticky)
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = DEF_CLK_PER_BIT,
  parameter int unsigned DATA_BITS   = DEF_DATA_BITS,
  parameter bit          PARITY_EN   = DEF_PARITY_EN,
  parameter bit          PARITY_ODD  = DEF_PARITY_ODD
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 RX,
  input  logic                 clr_rdy,
  output logic                 rdy,
  output logic [DATA_BITS-1:0] cmd,
  output logic                 frm_err,
  output logic                 par_err,
  output logic                 ovr_err
);

  localparam int unsigned CNT_W = $clog2(CLK_PER_BIT);
  localparam int unsigned BC_W  = $clog2(DATA_BITS + 1);
  localparam int unsigned HALF  = CLK_PER_BIT / 2;

  logic                 rx_s;
  uart_state_e          state_q;
  uart_state_e          state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [BC_W-1:0]      bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_bad_q;

  logic half_hit_c;
  logic bit_hit_c;
  logic last_bit_c;
  logic cnt_clr_c;
  logic bit_clr_c;
  logic shift_c;
  logic par_smp_c;
  logic done_c;

  uart_sync #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (RX),
    .q     (rx_s)
  );

  assign half_hit_c = (cnt_q == CNT_W'(HALF - 1));
  assign bit_hit_c  = (cnt_q == CNT_W'(CLK_PER_BIT - 1));
  assign last_bit_c = (bit_cnt_q == BC_W'(DATA_BITS - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!rx_s) state_d = START;
      end
      START: begin
        // Mid-start-bit check rejects glitches shorter than half a bit
        if (half_hit_c) state_d = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (bit_hit_c && last_bit_c) state_d = PARITY_EN ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_hit_c) state_d = STOP;
      end
      STOP: begin
        if (bit_hit_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath control decode
  always_comb begin
    cnt_clr_c = 1'b0;
    bit_clr_c = 1'b0;
    shift_c   = 1'b0;
    par_smp_c = 1'b0;
    done_c    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_clr_c = 1'b1;
        bit_clr_c = 1'b1;
      end
      START: begin
        cnt_clr_c = half_hit_c;
        bit_clr_c = 1'b1;
      end
      DATA: begin
        cnt_clr_c = bit_hit_c;
        shift_c   = bit_hit_c;
      end
      PARITY: begin
        cnt_clr_c = bit_hit_c;
        par_smp_c = bit_hit_c;
      end
      STOP: begin
        cnt_clr_c = bit_hit_c;
        done_c    = bit_hit_c;
      end
      default: begin
        cnt_clr_c = 1'b1;
        bit_clr_c = 1'b1;
      end
    endcase
  end

  // Baud/bit counters, shift register, parity check
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
    end else begin
      if (cnt_clr_c) cnt_q <= '0;
      else           cnt_q <= cnt_q + CNT_W'(1);

      if (bit_clr_c)    bit_cnt_q <= '0;
      else if (shift_c) bit_cnt_q <= bit_cnt_q + BC_W'(1);

      // LSB arrives first, so new bits enter at the top and walk down
      if (shift_c) shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};

      if (par_smp_c) par_bad_q <= rx_s ^ (^shift_q) ^ PARITY_ODD;
    end
  end

  // Consumer-facing result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy     <= 1'b0;
      cmd     <= '0;
      frm_err <= 1'b0;
      par_err <= 1'b0;
      ovr_err <= 1'b0;
    end else if (done_c) begin
      // Completion beats a same-cycle acknowledge; overrun only if unacknowledged
      rdy     <= 1'b1;
      cmd     <= shift_q;
      frm_err <= ~rx_s;
      par_err <= PARITY_EN & par_bad_q;
      ovr_err <= clr_rdy ? 1'b0 : (ovr_err | rdy);
    end else if (clr_rdy) begin
      rdy     <= 1'b0;
      ovr_err <= 1'b0;
    end
  end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter CLK_PER_BIT, default 2604, clk cycles per bit (legal >= 8).
REQ-002 Parameter DATA_BITS, default 8, data bits per frame (legal 5..9).
REQ-003 Parameter PARITY_EN, default 0, 1 = parity bit expected after data.
REQ-004 Parameter PARITY_ODD, default 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
REQ-005 Port: clk  input  1  system clock.
REQ-006 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-007 Port: RX  input  1  asynchronous serial line, idle high.
REQ-008 Port: clr_rdy  input  1  consumer acknowledge; clears rdy and ovr_err.
REQ-009 Port: rdy  output  1  received frame available.
REQ-010 Port: cmd  output  DATA_BITS  last received data word.
REQ-011 Port: frm_err  output  1  stop bit of last frame sampled low.
REQ-012 Port: par_err  output  1  parity mismatch in last frame; constant 0 when PARITY_EN=0.
REQ-013 Port: ovr_err  output  1  frame completed while rdy already high.

Function
REQ-014 RX SHALL pass a 2-flop synchronizer (flops preset to 1); all logic uses the synchronized value only.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE -> START on synchronized RX = 0; baud counter cleared to 0.
REQ-017 In START, at count CLK_PER_BIT/2 - 1 (integer divide): RX = 0 -> DATA with counter cleared; RX = 1 -> IDLE (false start, no outputs change).
REQ-018 In DATA/PARITY/STOP, a bit SHALL be sampled when counter reaches CLK_PER_BIT-1; counter then wraps to 0.
REQ-019 Data SHALL be shifted in LSB first; a bit counter (width $clog2(DATA_BITS+1)) counts samples; after DATA_BITS samples -> PARITY if PARITY_EN else STOP.
REQ-020 PARITY: sampled bit XOR reduction-XOR of data, XOR PARITY_ODD, nonzero = mismatch.
REQ-021 STOP: on stop sample -> IDLE; cycle after sample: cmd, frm_err (= ~stop bit), par_err loaded; rdy = 1.
REQ-022 Back-to-back frames: a start edge in the first IDLE cycle after STOP SHALL be accepted.
REQ-023 clr_rdy SHALL clear rdy and ovr_err next cycle; frame completion in the same cycle as clr_rdy wins (rdy stays 1, ovr_err not set).
REQ-024 Frame completion with rdy = 1 and no clr_rdy SHALL set ovr_err (sticky) and overwrite cmd.
REQ-025 cmd, frm_err, par_err SHALL hold between completions; not cleared by clr_rdy.
REQ-026 Baud counter width SHALL be $clog2(CLK_PER_BIT); no overflow path exists.

Reset
REQ-027 On rst_n low: state IDLE, counters 0, shift register 0, synchronizer 1, cmd 0, rdy 0, frm_err 0, par_err 0, ovr_err 0.
REQ-028 Reset mid-frame SHALL abort the frame with no rdy pulse; reception resumes at next start bit after release.

Structure
REQ-029 State enum type and default parameter constants SHALL live in shared package uart_pkg, also used by the transmitter.
REQ-030 Synchronizer SHALL be sub-module uart_sync (2-flop, parametrised reset value); everything else in uart_rx_cfg.

Verification (CLK_PER_BIT=16 unless stated)
REQ-031 Frame 0xA5, 8N1 -> rdy rises 1 cycle after stop sample, cmd=0xA5, frm_err=0, par_err=0.
REQ-032 RX low pulse of 5 cycles then high -> FSM returns to IDLE, rdy stays 0.
REQ-033 PARITY_EN=1, PARITY_ODD=0, frame 0x3C with parity bit 1 -> cmd=0x3C, par_err=1; parity bit 0 -> par_err=0.
REQ-034 Frame 0x55 with stop bit low -> rdy=1, cmd=0x55, frm_err=1.
REQ-035 Two back-to-back frames 0x12, 0x34, no clr_rdy -> cmd=0x34, ovr_err=1; clr_rdy -> rdy=0, ovr_err=0 next cycle.
REQ-036 DATA_BITS=7, CLK_PER_BIT=2604, frame 0x7F -> cmd=7'h7F; rst_n asserted mid-DATA -> all outputs 0, no rdy.
